pat_seq: RTL and testbench

Parametrised program sequencer for the pat pattern-processor family: owns the program counter and a bounded call/return stack. Applies one control-flow op per retired instruction: increment, forward/backward relative branch, call and return, under a condition code. Reports stack overflow and underflow as sticky errors. Sits between the instruction decoder and instruction memory, replacing the inline PC logic of the original core.

---
 rtl/pat_seq_pkg.sv | 37 +++
 rtl/pat_call_stack.sv | 57 +++++
 rtl/pat_seq.sv | 132 +++++++++++++
 tb/tb_pat_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pat_seq_pkg.sv
// Shared types for the pat sequencer: control-flow op and condition encodings,
// plus the condition evaluator used by pat_seq.
package pat_seq_pkg;

    typedef enum logic [2:0] {
        OP_INC  = 3'b000,
        OP_BF   = 3'b001,
        OP_BB   = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100,
        OP_LOOP = 3'b101,
        OP_LDLC = 3'b110,
        OP_RSV  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        C_ALWAYS = 2'b00,
        C_Z      = 2'b01,
        C_NZ     = 2'b10,
        C_C      = 2'b11
    } cond_e;

    // True when the selected condition holds for the sampled ALU flags.
    function automatic logic cond_met(input cond_e c, input logic flag_z, input logic flag_c);
        logic met;
        met = 1'b1;
        case (c)
            C_ALWAYS: met = 1'b1;
            C_Z:      met = flag_z;
            C_NZ:     met = !flag_z;
            C_C:      met = flag_c;
            default:  met = 1'b1;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/pat_call_stack.sv
// Bounded LIFO of return addresses; top entry is read combinationally so a
// pop can follow a push on the very next edge.
module pat_call_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SP_W  = 3,
    parameter int unsigned DW    = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   top,
    output logic [SP_W:0]   depth,
    output logic            full,
    output logic            empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [SP_W:0] depth_nxt;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_push   = push && !full;
        do_pop    = pop && !push && !empty;
        depth_nxt = depth;
        if (do_push) begin
            depth_nxt = depth + (SP_W+1)'(1);
        end else if (do_pop) begin
            depth_nxt = depth - (SP_W+1)'(1);
        end
    end

    // Occupancy and status flags are all flops, updated together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            depth <= depth_nxt;
            full  <= (depth_nxt == (SP_W+1)'(DEPTH));
            empty <= (depth_nxt == '0);
        end
    end

    // Entry storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[SP_W'(depth)] <= wdata;
        end
    end

    assign top = mem[SP_W'(depth - (SP_W+1)'(1))];

endmodule

// File: rtl/pat_seq.sv
// Program sequencer: PC, call/return stack and sticky stack errors.
// Optional hardware loop counter enabled by defining PAT_SEQ_LOOP_EN.
module pat_seq
    import pat_seq_pkg::*;
#(
    parameter int unsigned I_ADR_WIDTH = 10,
    parameter int unsigned OFS_WIDTH   = 8,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned SP_WIDTH    = 3,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   advance,
    input  logic [2:0]             op,
    input  logic [1:0]             cond,
    input  logic                   flag_z,
    input  logic                   flag_c,
    input  logic [OFS_WIDTH-1:0]   offset,
    input  logic                   err_clr,
    output logic [I_ADR_WIDTH-1:0] pc,
    output logic [SP_WIDTH:0]      depth,
    output logic                   stack_full,
    output logic                   stack_empty,
    output logic                   stack_ovf,
    output logic                   stack_udf
);

    logic [I_ADR_WIDTH-1:0] pc_nxt;
    logic [I_ADR_WIDTH-1:0] pc_inc;
    logic [I_ADR_WIDTH-1:0] ofs_ext;
    logic [I_ADR_WIDTH-1:0] stk_top;
    logic                   push;
    logic                   pop;
    logic                   ovf_set;
    logic                   udf_set;
    op_e                    op_eff;

`ifdef PAT_SEQ_LOOP_EN
    logic [OFS_WIDTH-1:0]   lc;
    logic [OFS_WIDTH-1:0]   lc_nxt;
`endif

    assign pc_inc  = pc + I_ADR_WIDTH'(1);
    assign ofs_ext = I_ADR_WIDTH'(offset);

    pat_call_stack #(
        .DEPTH (STACK_DEPTH),
        .SP_W  (SP_WIDTH),
        .DW    (I_ADR_WIDTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (pc_inc),
        .top   (stk_top),
        .depth (depth),
        .full  (stack_full),
        .empty (stack_empty)
    );

    // Next-PC and stack control; a failed condition degrades the op to INC.
    always_comb begin
        pc_nxt  = pc;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        op_eff  = cond_met(cond_e'(cond), flag_z, flag_c) ? op_e'(op) : OP_INC;
`ifdef PAT_SEQ_LOOP_EN
        lc_nxt  = lc;
`endif
        if (advance) begin
            pc_nxt = pc_inc;
            case (op_eff)
                OP_BF: pc_nxt = pc + ofs_ext;
                OP_BB: pc_nxt = pc - ofs_ext;
                OP_CALL: begin
                    if (stack_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        push   = 1'b1;
                        pc_nxt = pc + ofs_ext;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        udf_set = 1'b1;
                    end else begin
                        pop    = 1'b1;
                        pc_nxt = stk_top;
                    end
                end
`ifdef PAT_SEQ_LOOP_EN
                OP_LDLC: lc_nxt = offset;
                OP_LOOP: begin
                    if (lc != '0) begin
                        lc_nxt = lc - OFS_WIDTH'(1);
                        pc_nxt = pc - ofs_ext;
                    end
                end
`endif
                default: pc_nxt = pc_inc;
            endcase
        end
    end

    // A fresh error in the err_clr cycle keeps its flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= I_ADR_WIDTH'(RESET_PC);
            stack_ovf <= 1'b0;
            stack_udf <= 1'b0;
        end else begin
            pc        <= pc_nxt;
            stack_ovf <= ovf_set | (stack_ovf & ~err_clr);
            stack_udf <= udf_set | (stack_udf & ~err_clr);
        end
    end

`ifdef PAT_SEQ_LOOP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lc <= '0;
        end else begin
            lc <= lc_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pat_seq.sv
// Directed bench for pat_seq with hand-computed expected PC/stack values.
// Exercises the loop ops when built with PAT_SEQ_LOOP_EN, otherwise checks they act as INC.
module tb_pat_seq;

    logic       clk;
    logic       reset;
    logic       advance;
    logic [2:0] op;
    logic [1:0] cond;
    logic       flag_z;
    logic       flag_c;
    logic [7:0] offset;
    logic       err_clr;
    logic [9:0] pc;
    logic [3:0] depth;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_ovf;
    logic       stack_udf;

    int n_chk;
    int n_fail;

    pat_seq dut (
        .clk         (clk),
        .reset       (reset),
        .advance     (advance),
        .op          (op),
        .cond        (cond),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .offset      (offset),
        .err_clr     (err_clr),
        .pc          (pc),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_ovf   (stack_ovf),
        .stack_udf   (stack_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one retired op across one rising edge; outputs settle #1 after it.
    task automatic do_op(input logic [2:0] o, input logic [1:0] c, input logic [7:0] ofs);
        advance = 1'b1;
        op      = o;
        cond    = c;
        offset  = ofs;
        @(posedge clk);
        #1;
        advance = 1'b0;
        op      = 3'b000;
        cond    = 2'b00;
        offset  = 8'h00;
    endtask

    task automatic idle_cycle(input logic clr);
        err_clr = clr;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic chk_pc(input string name, input logic [9:0] exp);
        n_chk++;
        if (pc !== exp) begin
            n_fail++;
            $display("FAIL %s: pc=%h expected %h", name, pc, exp);
        end
    endtask

    task automatic chk_depth(input string name, input logic [3:0] exp);
        n_chk++;
        if (depth !== exp) begin
            n_fail++;
            $display("FAIL %s: depth=%0d expected %0d", name, depth, exp);
        end
    endtask

    task automatic chk_flags(input string name, input logic [3:0] exp);
        n_chk++;
        if ({stack_full, stack_empty, stack_ovf, stack_udf} !== exp) begin
            n_fail++;
            $display("FAIL %s: full,empty,ovf,udf=%b expected %b", name,
                     {stack_full, stack_empty, stack_ovf, stack_udf}, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        chk_pc("reset_pc", 10'h000);
        chk_depth("reset_depth", 4'd0);
        chk_flags("reset_flags", 4'b0100);
        reset = 1'b1;
    endtask

    task automatic test_inc();
        for (int i = 1; i <= 3; i++) begin
            do_op(3'b000, 2'b00, 8'h00);
            chk_pc("inc", 10'(i));
        end
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        chk_pc("advance_low_hold", 10'h003);
    endtask

    task automatic test_branch();
        do_op(3'b010, 2'b00, 8'h05);
        chk_pc("bb_wrap_down", 10'h3FE);
        do_op(3'b001, 2'b00, 8'h05);
        chk_pc("bf_wrap_up", 10'h003);
        do_op(3'b010, 2'b00, 8'h01);
        chk_pc("bb_1", 10'h002);
        do_op(3'b010, 2'b00, 8'h04);
        chk_pc("bb_4_wrap", 10'h3FE);
        do_op(3'b001, 2'b00, 8'h22);
        chk_pc("bf_22_wrap", 10'h020);
    endtask

    task automatic test_back_to_back();
        do_op(3'b011, 2'b00, 8'h10);
        chk_pc("call_pc", 10'h030);
        chk_depth("call_depth", 4'd1);
        chk_flags("call_flags", 4'b0000);
        do_op(3'b100, 2'b00, 8'h00);
        chk_pc("ret_pc", 10'h021);
        chk_depth("ret_depth", 4'd0);
        chk_flags("ret_flags", 4'b0100);
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 8; k++) begin
            do_op(3'b011, 2'b00, 8'h10);
            chk_pc("fill_call_pc", 10'(10'h031 + 10'h010 * k));
        end
        chk_depth("full_depth", 4'd8);
        chk_flags("full_flags", 4'b1000);
        do_op(3'b011, 2'b00, 8'h10);
        chk_pc("ovf_pc", 10'h0A2);
        chk_depth("ovf_depth", 4'd8);
        chk_flags("ovf_flags", 4'b1010);
        // Error raised in the same cycle as err_clr must stay set.
        err_clr = 1'b1;
        do_op(3'b011, 2'b00, 8'h10);
        err_clr = 1'b0;
        chk_pc("ovf_clr_pc", 10'h0A3);
        chk_flags("ovf_clr_race", 4'b1010);
        idle_cycle(1'b1);
        chk_flags("ovf_cleared", 4'b1000);
        for (int k = 7; k >= 0; k--) begin
            do_op(3'b100, 2'b00, 8'h00);
            chk_pc("lifo_ret_pc", 10'(10'h022 + 10'h010 * k));
            chk_depth("lifo_ret_depth", 4'(k));
        end
        chk_flags("drained_flags", 4'b0100);
    endtask

    task automatic test_underflow();
        do_op(3'b100, 2'b00, 8'h00);
        chk_pc("udf_pc", 10'h023);
        chk_depth("udf_depth", 4'd0);
        chk_flags("udf_flags", 4'b0101);
        idle_cycle(1'b1);
        chk_flags("udf_cleared", 4'b0100);
    endtask

    task automatic test_cond();
        flag_z = 1'b0;
        flag_c = 1'b0;
        do_op(3'b001, 2'b01, 8'h05);
        chk_pc("cond_z_false", 10'h024);
        flag_z = 1'b1;
        do_op(3'b001, 2'b01, 8'h05);
        chk_pc("cond_z_true", 10'h029);
        do_op(3'b001, 2'b10, 8'h05);
        chk_pc("cond_nz_false", 10'h02A);
        flag_c = 1'b1;
        do_op(3'b001, 2'b11, 8'h02);
        chk_pc("cond_c_true", 10'h02C);
        flag_c = 1'b0;
        do_op(3'b011, 2'b11, 8'h10);
        chk_pc("cond_call_false_pc", 10'h02D);
        chk_depth("cond_call_false_depth", 4'd0);
        do_op(3'b100, 2'b11, 8'h00);
        chk_pc("cond_ret_false_pc", 10'h02E);
        chk_flags("cond_ret_false_flags", 4'b0100);
        flag_z = 1'b0;
    endtask

    task automatic test_advance_gate();
        op     = 3'b011;
        offset = 8'h40;
        @(posedge clk);
        #1;
        op     = 3'b000;
        offset = 8'h00;
        chk_pc("no_adv_pc", 10'h02E);
        chk_depth("no_adv_depth", 4'd0);
    endtask

    task automatic test_loop();
`ifdef PAT_SEQ_LOOP_EN
        int body;
        body = 0;
        do_op(3'b110, 2'b00, 8'h02);
        chk_pc("ldlc_pc", 10'h02F);
        for (int it = 0; it < 6 && pc == 10'h02F; it++) begin
            do_op(3'b000, 2'b00, 8'h00);
            body++;
            do_op(3'b101, 2'b00, 8'h01);
        end
        chk_pc("loop_exit_pc", 10'h031);
        n_chk++;
        if (body !== 3) begin
            n_fail++;
            $display("FAIL loop_body_count: got %0d expected %0d", body, 3);
        end
        do_op(3'b101, 2'b00, 8'h01);
        chk_pc("loop_lc_zero", 10'h032);
        do_op(3'b010, 2'b00, 8'h04);
`else
        do_op(3'b101, 2'b00, 8'h05);
        chk_pc("loop_as_inc", 10'h02F);
        do_op(3'b110, 2'b00, 8'h05);
        chk_pc("ldlc_as_inc", 10'h030);
        do_op(3'b010, 2'b00, 8'h02);
`endif
        do_op(3'b111, 2'b00, 8'h05);
        chk_pc("reserved_as_inc", 10'h02F);
    endtask

    task automatic test_reset_mid();
        do_op(3'b011, 2'b00, 8'h20);
        chk_pc("pre_rst_call", 10'h04F);
        chk_depth("pre_rst_depth", 4'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_pc("mid_rst_pc", 10'h000);
        chk_depth("mid_rst_depth", 4'd0);
        chk_flags("mid_rst_flags", 4'b0100);
        #2;
        reset = 1'b1;
        do_op(3'b000, 2'b00, 8'h00);
        chk_pc("post_rst_inc", 10'h001);
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        advance = 1'b0;
        op      = 3'b000;
        cond    = 2'b00;
        flag_z  = 1'b0;
        flag_c  = 1'b0;
        offset  = 8'h00;
        err_clr = 1'b0;
        test_reset();
        test_inc();
        test_branch();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_cond();
        test_advance_gate();
        test_loop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
